// File: rtl/i2c_flash_responder_if.sv
// Pad-side I2C lines, memory port and status of the flash I2C responder.
// The slave modport is the responder's view; master is the bus/memory side.
interface i2c_flash_responder_if #(
  parameter int ADDR_W = 8
);
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/i2c_flash_responder.sv
// I2C responder with a one-byte memory pointer driving a synchronous memory port.
// Pad events act 3 clk after the pins change; the bus is paced by the master's SCL.
module i2c_flash_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_flash_responder_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_MEM_ADDR, S_ACK_ADDR,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_WAIT
  } state_t;

  state_t            state;
  logic              scl_s1, scl_s2, scl_h;
  logic              sda_s1, sda_s2, sda_h;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic              rw;
  logic              ack_drv;
  logic              re_d;
  logic              sda_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic              busy;

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign last_bit  = (bit_cnt == 4'd7);
  assign rx_byte   = {shift[6:0], sda_s2};

  assign bus.sda_oe    = sda_oe;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.busy      = busy;

  // Synchronizers idle high so reset never looks like a START or STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      scl_s1 <= bus.scl_in;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= bus.sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      re_d      <= 1'b0;
      sda_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d   <= mem_re;
      // Read data arrives the clk after the strobe; load it one clk later still.
      if (re_d)   shift    <= bus.mem_rdata;
      if (mem_we) mem_addr <= mem_addr + 1'b1;

      if (start_det) begin
        state   <= S_DEV_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_DEV_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt <= 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw    <= rx_byte[0];
                state <= S_ACK_DEV;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_MEM_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt  <= 4'd0;
              mem_addr <= ADDR_W'(rx_byte);
              state    <= S_ACK_ADDR;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              bit_cnt   <= 4'd0;
              mem_wdata <= rx_byte;
              mem_we    <= 1'b1;
              state     <= S_ACK_WR;
            end
          end
          S_ACK_DEV: begin
            if (scl_rise && ack_drv && rw) mem_re <= 1'b1;
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                // The fall that ends the ACK also presents the first read bit.
                if (rw) begin
                  sda_oe  <= ~shift[7];
                  shift   <= {shift[6:0], 1'b0};
                  bit_cnt <= 4'd1;
                  state   <= S_RD_DATA;
                end else begin
                  sda_oe  <= 1'b0;
                  state   <= S_MEM_ADDR;
                end
              end
            end
          end
          S_ACK_ADDR, S_ACK_WR: if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe  <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_drv <= 1'b0;
              state   <= S_WR_DATA;
            end
          end
          S_RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe   <= 1'b0;
              bit_cnt  <= 4'd0;
              mem_addr <= mem_addr + 1'b1;
              state    <= S_RD_ACK;
            end else begin
              sda_oe  <= ~shift[7];
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_RD_ACK: if (scl_rise) begin
            if (!sda_s2) begin
              mem_re <= 1'b1;
              state  <= S_RD_DATA;
            end else begin
              state  <= S_WAIT;
            end
          end
          S_WAIT: sda_oe <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_flash_responder.sv
// Directed bench: an I2C master drives the wired-AND bus; memory reads return addr^8'h3C.
module tb_i2c_flash_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_flash_responder_if #(.ADDR_W(8)) bus ();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_flash_responder #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int we_n = 0, re_n = 0, both_n = 0;
  logic [7:0] we_addr [64];
  logic [7:0] we_data [64];

  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= bus.mem_addr ^ 8'h3C;
    if (bus.mem_we) begin
      we_addr[we_n[5:0]] <= bus.mem_addr;
      we_data[we_n[5:0]] <= bus.mem_wdata;
    end
    we_n   <= we_n + (bus.mem_we ? 1 : 0);
    re_n   <= re_n + (bus.mem_re ? 1 : 0);
    both_n <= both_n + ((bus.mem_we && bus.mem_re) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq;
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wq;
    scl_m = 1'b1; wq;
    sda_m = 1'b0; wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq;
    scl_m = 1'b1; wq;
    sda_m = 1'b1; wq;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq;
    scl_m = 1'b1; wq; wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic ack_bit(input string tag, input logic exp_oe);
    sda_m = 1'b1; wq;
    scl_m = 1'b1; wq;
    chk(tag, 32'(bus.sda_oe), 32'(exp_oe));
    wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(tag, exp_ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq;
      scl_m = 1'b1; wq;
      b[i] = bus.sda_in;
      wq;
      scl_m = 1'b0; wq;
    end
  endtask

  initial begin
    logic [7:0] rb;
    int we0, re0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sda_oe",   32'(bus.sda_oe),    0);
    chk("rst_busy",     32'(bus.busy),      0);
    chk("rst_mem_addr", 32'(bus.mem_addr),  0);
    chk("rst_mem_we",   32'(bus.mem_we),    0);
    chk("rst_mem_re",   32'(bus.mem_re),    0);
    chk("rst_wdata",    32'(bus.mem_wdata), 0);
    rst_n = 1'b1; wq;

    // 1: write burst of two bytes at 0x10
    we0 = we_n;
    i2c_start;
    send_byte(8'hA0, "t1_ack_dev", 1'b1);
    chk("t1_busy", 32'(bus.busy), 1);
    send_byte(8'h10, "t1_ack_addr", 1'b1);
    send_byte(8'h55, "t1_ack_d0", 1'b1);
    send_byte(8'hAA, "t1_ack_d1", 1'b1);
    i2c_stop; wq;
    chk("t1_we_count", 32'(we_n - we0), 2);
    chk("t1_addr0", 32'(we_addr[we0[5:0]]), 32'h10);
    chk("t1_data0", 32'(we_data[we0[5:0]]), 32'h55);
    chk("t1_addr1", 32'(we_addr[we0[5:0] + 6'd1]), 32'h11);
    chk("t1_data1", 32'(we_data[we0[5:0] + 6'd1]), 32'hAA);
    chk("t1_ptr", 32'(bus.mem_addr), 32'h12);
    chk("t1_busy_end", 32'(bus.busy), 0);

    // 2: set pointer, repeated START, read two bytes
    we0 = we_n; re0 = re_n;
    i2c_start;
    send_byte(8'hA0, "t2_ack_dev", 1'b1);
    send_byte(8'h20, "t2_ack_addr", 1'b1);
    i2c_start;
    send_byte(8'hA1, "t2_ack_rd", 1'b1);
    read_byte(rb);
    chk("t2_byte0", 32'(rb), 32'h1C);
    send_bit(1'b0);
    read_byte(rb);
    chk("t2_byte1", 32'(rb), 32'h1D);
    send_bit(1'b1);
    i2c_stop; wq;
    chk("t2_re_count", 32'(re_n - re0), 2);
    chk("t2_we_count", 32'(we_n - we0), 0);
    chk("t2_ptr", 32'(bus.mem_addr), 32'h22);

    // 3: address mismatch is ignored until the next START
    we0 = we_n; re0 = re_n;
    i2c_start;
    send_byte(8'hA2, "t3_nack_dev", 1'b0);
    send_byte(8'h10, "t3_nack_b1", 1'b0);
    send_byte(8'h55, "t3_nack_b2", 1'b0);
    chk("t3_busy", 32'(bus.busy), 1);
    chk("t3_we_count", 32'(we_n - we0), 0);
    chk("t3_re_count", 32'(re_n - re0), 0);
    i2c_stop; wq;
    chk("t3_busy_end", 32'(bus.busy), 0);

    // 4: pointer wraps from 0xFF to 0x00
    we0 = we_n;
    i2c_start;
    send_byte(8'hA0, "t4_ack_dev", 1'b1);
    send_byte(8'hFF, "t4_ack_addr", 1'b1);
    send_byte(8'h11, "t4_ack_d0", 1'b1);
    send_byte(8'h22, "t4_ack_d1", 1'b1);
    i2c_stop; wq;
    chk("t4_we_count", 32'(we_n - we0), 2);
    chk("t4_addr0", 32'(we_addr[we0[5:0]]), 32'hFF);
    chk("t4_data0", 32'(we_data[we0[5:0]]), 32'h11);
    chk("t4_addr1", 32'(we_addr[we0[5:0] + 6'd1]), 32'h00);
    chk("t4_data1", 32'(we_data[we0[5:0] + 6'd1]), 32'h22);
    chk("t4_ptr", 32'(bus.mem_addr), 32'h01);

    // 5: STOP after a partial data byte writes nothing
    we0 = we_n;
    i2c_start;
    send_byte(8'hA0, "t5_ack_dev", 1'b1);
    send_byte(8'h05, "t5_ack_addr", 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop; wq;
    chk("t5_we_count", 32'(we_n - we0), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_sda_oe", 32'(bus.sda_oe), 0);
    chk("t5_ptr", 32'(bus.mem_addr), 32'h05);

    // 6: async reset while driving a read bit (mem[0x05] = 0x39, MSB 0)
    i2c_start;
    send_byte(8'hA1, "t6_ack_rd", 1'b1);
    chk("t6_drive_low", 32'(bus.sda_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sda_oe", 32'(bus.sda_oe), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_ptr", 32'(bus.mem_addr), 0);
    wq;
    rst_n = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    wq; wq;
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_idle_sda_oe", 32'(bus.sda_oe), 0);

    chk("we_re_exclusive", 32'(both_n), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
